// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg -- shared types for the 2-D address scan sequencer.
//
//   SCAN_ADDR_W  : default width of every address, count and stride field
//   scan_state_e : controller FSM states (IDLE, RUN, DONE)
//   scan_desc_t  : latched scan descriptor (offset, x_max, y_max, strides)
//
// The descriptor struct is sized by SCAN_ADDR_W, so the top-level ADDR_W
// parameter is expected to stay at that value.
// -----------------------------------------------------------------------------
package scan_pkg;

  localparam int SCAN_ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [SCAN_ADDR_W-1:0] offset;
    logic [SCAN_ADDR_W-1:0] x_max;
    logic [SCAN_ADDR_W-1:0] y_max;
    logic [SCAN_ADDR_W-1:0] x_stride;
    logic [SCAN_ADDR_W-1:0] y_stride;
  } scan_desc_t;

endpackage

// File: rtl/scan_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// scan_seq_ctrl_if -- descriptor / address / status bundle of scan_seq_ctrl.
//
//   cfg_valid/cfg_ready          : descriptor handshake
//   cfg_offset, cfg_x_stride,
//   cfg_y_stride                 : base address, inner and outer step
//   cfg_x_max, cfg_y_max         : inner and outer iteration counts
//   addr_valid/addr_ready        : address stream handshake
//   addr, last                   : generated address, final-address marker
//   busy, done                   : scan in progress, one-cycle completion pulse
//   abort                        : terminate scan (only with SCAN_SEQ_ABORT_EN)
//
// modport master : the controller side (scan_seq_ctrl)
// modport slave  : the side that supplies descriptors and consumes addresses
// -----------------------------------------------------------------------------
interface scan_seq_ctrl_if #(
  parameter int ADDR_W = 16
);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_offset;
  logic [ADDR_W-1:0] cfg_x_stride;
  logic [ADDR_W-1:0] cfg_y_stride;
  logic [ADDR_W-1:0] cfg_x_max;
  logic [ADDR_W-1:0] cfg_y_max;
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr;
  logic              last;
  logic              busy;
  logic              done;

`ifdef SCAN_SEQ_ABORT_EN
  logic              abort;

  modport master (
    input  cfg_valid, cfg_offset, cfg_x_stride, cfg_y_stride, cfg_x_max,
           cfg_y_max, addr_ready, abort,
    output cfg_ready, addr_valid, addr, last, busy, done
  );

  modport slave (
    output cfg_valid, cfg_offset, cfg_x_stride, cfg_y_stride, cfg_x_max,
           cfg_y_max, addr_ready, abort,
    input  cfg_ready, addr_valid, addr, last, busy, done
  );
`else
  modport master (
    input  cfg_valid, cfg_offset, cfg_x_stride, cfg_y_stride, cfg_x_max,
           cfg_y_max, addr_ready,
    output cfg_ready, addr_valid, addr, last, busy, done
  );

  modport slave (
    output cfg_valid, cfg_offset, cfg_x_stride, cfg_y_stride, cfg_x_max,
           cfg_y_max, addr_ready,
    input  cfg_ready, addr_valid, addr, last, busy, done
  );
`endif

endinterface

// File: rtl/scan_walk.sv
// -----------------------------------------------------------------------------
// scan_walk -- x/y iteration counters and address accumulators.
//
//   clk, rst        : clock, asynchronous active-high reset
//   clear           : zero x, y, x_acc, y_acc (descriptor accepted)
//   step            : advance one position (address handshake, not final)
//   x_max, y_max    : latched iteration counts
//   x_stride,
//   y_stride        : latched inner / outer step
//   x_acc, y_acc    : accumulated inner / outer offsets (wrap mod 2^ADDR_W)
//   x_wrap, y_wrap  : x == x_max-1, y == y_max-1
//
// Stepping when both wrap flags are set holds everything; the controller
// leaves RUN on that handshake instead.
// -----------------------------------------------------------------------------
module scan_walk #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic [ADDR_W-1:0] x_max,
  input  logic [ADDR_W-1:0] y_max,
  input  logic [ADDR_W-1:0] x_stride,
  input  logic [ADDR_W-1:0] y_stride,
  output logic [ADDR_W-1:0] x_acc,
  output logic [ADDR_W-1:0] y_acc,
  output logic              x_wrap,
  output logic              y_wrap
);

  logic [ADDR_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0] y_q, y_d;
  logic [ADDR_W-1:0] x_acc_q, x_acc_d;
  logic [ADDR_W-1:0] y_acc_q, y_acc_d;

  assign x_wrap = (x_q == x_max - ADDR_W'(1));
  assign y_wrap = (y_q == y_max - ADDR_W'(1));
  assign x_acc  = x_acc_q;
  assign y_acc  = y_acc_q;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    x_acc_d = x_acc_q;
    y_acc_d = y_acc_q;
    if (clear) begin
      x_d     = '0;
      y_d     = '0;
      x_acc_d = '0;
      y_acc_d = '0;
    end else if (step) begin
      if (!x_wrap) begin
        x_d     = x_q + ADDR_W'(1);
        x_acc_d = x_acc_q + x_stride;
      end else if (!y_wrap) begin
        // end of a row: restart inner walk, move outer one step
        x_d     = '0;
        x_acc_d = '0;
        y_d     = y_q + ADDR_W'(1);
        y_acc_d = y_acc_q + y_stride;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      x_acc_q <= '0;
      y_acc_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      x_acc_q <= x_acc_d;
      y_acc_q <= y_acc_d;
    end
  end

endmodule

// File: rtl/scan_seq_ctrl.sv
// -----------------------------------------------------------------------------
// scan_seq_ctrl -- 2-D strided address sequencer.
//
// Accepts a descriptor (offset, x_max, y_max, x_stride, y_stride) and emits
// x_max*y_max addresses  offset + x*x_stride + y*y_stride  (mod 2^ADDR_W),
// x innermost, on a valid/ready stream. last marks the final address; done
// pulses for one cycle after the scan (or straight after accepting an empty
// descriptor).
//
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : scan_seq_ctrl_if.master (descriptor, address stream, status)
//
// Optional feature macro: SCAN_SEQ_ABORT_EN adds bus.abort, which ends a
// running scan (DONE next cycle, no more addresses).
// -----------------------------------------------------------------------------
module scan_seq_ctrl
  import scan_pkg::*;
#(
  parameter int ADDR_W = SCAN_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  scan_seq_ctrl_if.master   bus
);

  scan_state_e       state_q, state_d;
  scan_desc_t        desc_q, desc_d;

  logic              walk_clear;
  logic              walk_step;
  logic              x_wrap;
  logic              y_wrap;
  logic [ADDR_W-1:0] x_acc;
  logic [ADDR_W-1:0] y_acc;
  logic              in_run;
  logic              last_w;

  scan_walk #(
    .ADDR_W (ADDR_W)
  ) u_walk (
    .clk      (clk),
    .rst      (rst),
    .clear    (walk_clear),
    .step     (walk_step),
    .x_max    (desc_q.x_max),
    .y_max    (desc_q.y_max),
    .x_stride (desc_q.x_stride),
    .y_stride (desc_q.y_stride),
    .x_acc    (x_acc),
    .y_acc    (y_acc),
    .x_wrap   (x_wrap),
    .y_wrap   (y_wrap)
  );

  assign in_run = (state_q == ST_RUN);
  assign last_w = in_run && x_wrap && y_wrap;

  always_comb begin
    state_d    = state_q;
    desc_d     = desc_q;
    walk_clear = 1'b0;
    walk_step  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cfg_valid) begin
          desc_d.offset   = bus.cfg_offset;
          desc_d.x_max    = bus.cfg_x_max;
          desc_d.y_max    = bus.cfg_y_max;
          desc_d.x_stride = bus.cfg_x_stride;
          desc_d.y_stride = bus.cfg_y_stride;
          walk_clear      = 1'b1;
          // empty scan: no addresses, go straight to the done pulse
          if (bus.cfg_x_max == '0 || bus.cfg_y_max == '0)
            state_d = ST_DONE;
          else
            state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.addr_ready) begin
          if (last_w) state_d   = ST_DONE;
          else        walk_step = 1'b1;
        end
`ifdef SCAN_SEQ_ABORT_EN
        // abort wins over any handshake; a coincident final handshake
        // lands in the same DONE, so still a single done pulse
        if (bus.abort) begin
          state_d   = ST_DONE;
          walk_step = 1'b0;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      desc_q  <= '0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
    end
  end

  // addr is a pure function of registers, so it is stable during stalls
  assign bus.addr       = desc_q.offset + x_acc + y_acc;
  assign bus.last       = last_w;
  assign bus.addr_valid = in_run;
  assign bus.cfg_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign bus.done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_seq_ctrl -- directed, table-driven bench for scan_seq_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_scan_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  scan_seq_ctrl_if #(.ADDR_W(16)) bus ();

  scan_seq_ctrl #(.ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic [15:0] offset;
    logic [15:0] x_max;
    logic [15:0] y_max;
    logic [15:0] x_stride;
    logic [15:0] y_stride;
    int          n;
    bit          stall;
    logic [15:0] exp [8];
  } scan_vec_t;

  scan_vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_cfg(input scan_vec_t v);
    bus.cfg_valid    = 1'b1;
    bus.cfg_offset   = v.offset;
    bus.cfg_x_max    = v.x_max;
    bus.cfg_y_max    = v.y_max;
    bus.cfg_x_stride = v.x_stride;
    bus.cfg_y_stride = v.y_stride;
  endtask

  task automatic run_scan(input scan_vec_t v, input string tag);
    int k = 0;
    int cyc = 0;
    bit holding = 0;
    bit rdy;
    logic [15:0] held = '0;
    @(negedge clk);
    check({tag, " cfg_ready idle"}, bus.cfg_ready, 1);
    drive_cfg(v);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    if (v.n == 0) begin
      check({tag, " empty no addr_valid"}, bus.addr_valid, 0);
      check({tag, " empty done"}, bus.done, 1);
      @(negedge clk);
      check({tag, " empty done clear"}, bus.done, 0);
      check({tag, " empty cfg_ready"}, bus.cfg_ready, 1);
      return;
    end
    check({tag, " first addr_valid"}, bus.addr_valid, 1);
    while (k < v.n && cyc < 200) begin
      if (holding) check({tag, " stall hold"}, bus.addr, held);
      if (bus.addr_valid !== 1'b1 || bus.done !== 1'b0) begin
        check({tag, " valid during scan"}, {bus.addr_valid, bus.done}, 2'b10);
        break;
      end
      // stall pattern 1,0,0,1 repeating
      rdy = v.stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      bus.addr_ready = rdy;
      if (rdy) begin
        check($sformatf("%s addr[%0d]", tag, k), bus.addr, v.exp[k]);
        check($sformatf("%s last[%0d]", tag, k), bus.last, (k == v.n - 1));
        k++;
        holding = 0;
      end else begin
        held    = bus.addr;
        holding = 1;
      end
      cyc++;
      @(negedge clk);
    end
    bus.addr_ready = 1'b0;
    check({tag, " handshake count"}, k, v.n);
    check({tag, " done pulse"}, bus.done, 1);
    check({tag, " no addr after last"}, bus.addr_valid, 0);
    @(negedge clk);
    check({tag, " done clear"}, bus.done, 0);
    check({tag, " back idle"}, bus.cfg_ready, 1);
    check({tag, " busy clear"}, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_valid = 0; bus.cfg_offset = 0; bus.cfg_x_max = 0; bus.cfg_y_max = 0;
    bus.cfg_x_stride = 0; bus.cfg_y_stride = 0; bus.addr_ready = 0;
`ifdef SCAN_SEQ_ABORT_EN
    bus.abort = 0;
`endif

    vecs[0] = '{16'd100, 16'd3, 16'd2, 16'd4, 16'd50, 6, 1'b0,
               '{16'd100, 16'd104, 16'd108, 16'd150, 16'd154, 16'd158, 16'd0, 16'd0}};
    vecs[1] = '{16'd100, 16'd3, 16'd2, 16'd4, 16'd50, 6, 1'b1,
               '{16'd100, 16'd104, 16'd108, 16'd150, 16'd154, 16'd158, 16'd0, 16'd0}};
    vecs[2] = '{16'h1234, 16'd0, 16'd5, 16'd1, 16'd1, 0, 1'b0,
               '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
    vecs[3] = '{16'hFFF0, 16'd4, 16'd1, 16'd8, 16'd0, 4, 1'b0,
               '{16'hFFF0, 16'hFFF8, 16'h0000, 16'h0008, 16'd0, 16'd0, 16'd0, 16'd0}};
    vecs[4] = '{16'h1000, 16'd2, 16'd2, 16'd1, 16'h0100, 4, 1'b1,
               '{16'h1000, 16'h1001, 16'h1100, 16'h1101, 16'd0, 16'd0, 16'd0, 16'd0}};
    vecs[5] = '{16'd7, 16'd1, 16'd3, 16'd9, 16'd3, 3, 1'b0,
               '{16'd7, 16'd10, 16'd13, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
    vecs[6] = '{16'd55, 16'd3, 16'd0, 16'd1, 16'd1, 0, 1'b0,
               '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};

    // asynchronous reset, observed before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst cfg_ready", bus.cfg_ready, 1);
    check("rst addr_valid", bus.addr_valid, 0);
    check("rst addr", bus.addr, 0);
    check("rst last", bus.last, 0);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_scan(vecs[i], $sformatf("vec%0d", i));

    // descriptor offered while busy waits and is then taken intact
    @(negedge clk);
    bus.cfg_valid = 1; bus.cfg_offset = 16'd5; bus.cfg_x_max = 16'd1;
    bus.cfg_y_max = 16'd2; bus.cfg_x_stride = 16'd0; bus.cfg_y_stride = 16'd1;
    @(negedge clk);
    bus.cfg_offset = 16'd200; bus.cfg_x_max = 16'd2; bus.cfg_y_max = 16'd1;
    bus.cfg_x_stride = 16'd1; bus.cfg_y_stride = 16'd7;
    bus.addr_ready = 1;
    check("hold A addr0", bus.addr, 16'd5);
    check("hold cfg_ready run", bus.cfg_ready, 0);
    @(negedge clk);
    check("hold A addr1", bus.addr, 16'd6);
    check("hold A last", bus.last, 1);
    @(negedge clk);
    check("hold done", bus.done, 1);
    check("hold cfg_ready done", bus.cfg_ready, 0);
    @(negedge clk);
    check("hold cfg_ready idle", bus.cfg_ready, 1);
    @(negedge clk);
    bus.cfg_valid = 0;
    check("hold B addr0", bus.addr, 16'd200);
    check("hold B valid", bus.addr_valid, 1);
    @(negedge clk);
    check("hold B addr1", bus.addr, 16'd201);
    check("hold B last", bus.last, 1);
    @(negedge clk);
    bus.addr_ready = 0;
    check("hold B done", bus.done, 1);
    @(negedge clk);

    // reset in the middle of a scan discards it without a done pulse
    drive_cfg(vecs[0]);
    @(negedge clk);
    bus.cfg_valid = 0;
    bus.addr_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check("midrst addr before", bus.addr, 16'd108);
    bus.addr_ready = 0;
    #2 rst = 1'b1;
    #1;
    check("midrst addr_valid", bus.addr_valid, 0);
    check("midrst addr", bus.addr, 0);
    check("midrst busy", bus.busy, 0);
    check("midrst done", bus.done, 0);
    check("midrst cfg_ready", bus.cfg_ready, 1);
    @(negedge clk);
    check("midrst done held", bus.done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst done after", bus.done, 0);
    check("midrst busy after", bus.busy, 0);
    run_scan(vecs[3], "after_rst");

`ifdef SCAN_SEQ_ABORT_EN
    // abort after the third handshake
    @(negedge clk);
    drive_cfg(vecs[0]);
    @(negedge clk);
    bus.cfg_valid = 0;
    bus.addr_ready = 1;
    check("abort addr0", bus.addr, 16'd100);
    @(negedge clk);
    check("abort addr1", bus.addr, 16'd104);
    @(negedge clk);
    check("abort addr2", bus.addr, 16'd108);
    @(negedge clk);
    bus.addr_ready = 0;
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
    check("abort done", bus.done, 1);
    check("abort no addr", bus.addr_valid, 0);
    @(negedge clk);
    check("abort done clear", bus.done, 0);
    check("abort idle", bus.cfg_ready, 1);

    // abort coinciding with the final handshake: one done pulse
    drive_cfg(vecs[5]);
    @(negedge clk);
    bus.cfg_valid = 0;
    bus.addr_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check("abort_last addr", bus.addr, 16'd13);
    check("abort_last last", bus.last, 1);
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
    bus.addr_ready = 0;
    check("abort_last done", bus.done, 1);
    @(negedge clk);
    check("abort_last done clear", bus.done, 0);
    @(negedge clk);
    check("abort_last no 2nd done", bus.done, 0);

    // abort while idle has no effect
    bus.abort = 1;
    @(negedge clk);
    @(negedge clk);
    check("abort idle busy", bus.busy, 0);
    check("abort idle done", bus.done, 0);
    bus.abort = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_seq_ctrl.md
SCAN_SEQ_CTRL -- requirements
Module: scan_seq_ctrl

Interface
REQ-001 Parameter: ADDR_W, 16, width of every address, count and stride field.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cfg_valid  in  1  descriptor present.
REQ-005 cfg_ready  out  1  controller can accept a descriptor.
REQ-006 cfg_offset, cfg_x_stride, cfg_y_stride  in  ADDR_W each  base address, inner step, outer step.
REQ-007 cfg_x_max, cfg_y_max  in  ADDR_W each  inner and outer iteration counts.
REQ-008 addr_valid  out  1  addr is valid; addr_ready  in  1  consumer accepts.
REQ-009 addr  out  ADDR_W  generated address; last  out  1  marks final address of the scan.
REQ-010 busy  out  1  scan in progress; done  out  1  one-cycle completion pulse.
REQ-011 abort  in  1  terminate current scan (present only with SCAN_SEQ_ABORT_EN).

Function
REQ-012 FSM states IDLE, RUN, DONE; cfg_ready SHALL be 1 only in IDLE.
REQ-013 On cfg_valid&&cfg_ready the block SHALL latch all cfg_* fields, clear x, y, x_acc, y_acc, and enter RUN next cycle.
REQ-014 If the latched x_max==0 or y_max==0, the block SHALL go IDLE->DONE directly, with no addr_valid.
REQ-015 In RUN addr_valid SHALL be 1; addr = offset + x_acc + y_acc, modulo 2^ADDR_W, sourced only from registers.
REQ-016 First addr_valid SHALL assert exactly one cycle after descriptor acceptance.
REQ-017 While addr_valid && !addr_ready, addr, last and all counters SHALL hold unchanged.
REQ-018 On handshake with x != x_max-1: x+=1, x_acc+=x_stride (wrapping).
REQ-019 On handshake with x == x_max-1 and y != y_max-1: x=0, x_acc=0, y+=1, y_acc+=y_stride (wrapping).
REQ-020 On handshake with x==x_max-1 and y==y_max-1 (last==1): transition RUN->DONE.
REQ-021 last SHALL equal (x==x_max-1)&&(y==y_max-1) while in RUN, else 0.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE; busy=1 in RUN and DONE.
REQ-023 Exactly x_max*y_max handshakes SHALL occur per non-empty descriptor.
REQ-024 A descriptor offered while not IDLE SHALL wait (cfg_ready=0) without being lost or corrupted.

Reset
REQ-025 rst SHALL immediately force IDLE, cfg_ready=1, addr_valid=0, last=0, busy=0, done=0, addr=0, all counters and latched fields 0.
REQ-026 rst mid-scan SHALL discard the scan with no done pulse.

Configuration
REQ-027 Macro SCAN_SEQ_ABORT_EN: when defined, abort port exists; abort=1 in RUN SHALL move to DONE next cycle (done pulses, no further addresses), abort ignored in IDLE/DONE; abort and a final handshake in the same cycle SHALL yield one done pulse.
REQ-028 Without SCAN_SEQ_ABORT_EN the abort port and logic SHALL be absent; behaviour otherwise identical.

Structure
REQ-029 Shared package scan_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the descriptor struct type (offset, x_max, y_max, x_stride, y_stride).
REQ-030 One sub-module scan_walk SHALL hold the x/y counters and accumulators, with step, clear and wrap outputs; FSM and handshakes stay in the top.

Verification
REQ-031 offset=100, x_max=3, y_max=2, x_stride=4, y_stride=50, addr_ready=1 -> addrs 100,104,108,150,154,158; last on 158; done one cycle later.
REQ-032 Same descriptor, addr_ready toggled 1,0,0,1... -> identical address sequence, addr held stable in stall cycles.
REQ-033 x_max=0, y_max=5 -> no addr_valid; done one cycle after acceptance.
REQ-034 offset=16'hFFF0, x_max=4, x_stride=8, y_max=1 -> addrs FFF0, FFF8, 0000, 0008 (wrap).
REQ-035 rst asserted after 2 handshakes of REQ-031 scan -> all outputs zero asynchronously, no done; new descriptor then runs from its first address.
REQ-036 With SCAN_SEQ_ABORT_EN, abort after third handshake of REQ-031 -> only 100,104,108 emitted, single done pulse, return to IDLE.
